mult_div_unit: RTL

//  Iterative multiply/divide unit for the multicycle MIPS datapath. Executes MULT, MULTU, DIV
//  and DIVU into the architectural HI/LO registers. Also services MTHI/MTLO writes.

---
 rtl/mult_div_unit_if.sv | 26 ++
 rtl/mult_div_unit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/mult_div_unit_if.sv
// Bus between the control unit and the multiply/divide unit.
// The master drives the operation request and MTHI/MTLO data; the slave returns HI/LO and status.
interface mult_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             hiwrite;
  logic             lowrite;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, srca, srcb, hiwrite, lowrite,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, srca, srcb, hiwrite, lowrite,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// It runs on operand magnitudes over WIDTH cycles, then applies sign correction in FIX.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  mult_div_unit_if.slave bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned AW = 2 * WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [AW-1:0]      r_acc;
  logic [WIDTH-1:0]   r_b;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dz;

  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_qbit;
  logic [AW-1:0]      w_mul_next;
  logic [AW-1:0]      w_div_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  // Operand magnitudes captured at launch; op[0]=1 selects the unsigned variants.
  assign w_signed = ~bus.op[0];
  assign w_a_neg  = w_signed & bus.srca[WIDTH-1];
  assign w_b_neg  = w_signed & bus.srcb[WIDTH-1];
  assign w_mag_a  = w_a_neg ? (-bus.srca) : bus.srca;
  assign w_mag_b  = w_b_neg ? (-bus.srcb) : bus.srcb;

  // Shift-add step: the multiplier drains out of the low half as the product fills in.
  assign w_sum      = r_acc[2*WIDTH:WIDTH] + (r_acc[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {1'b0, w_sum, r_acc[WIDTH-1:1]};

  // Restoring divide step: partial remainder in the top WIDTH+1 bits, quotient shifts in below.
  assign w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_qbit     = (w_shift >= {1'b0, r_b});
  assign w_diff     = w_shift - {1'b0, r_b};
  assign w_div_next = {(w_qbit ? w_diff : w_shift), r_acc[WIDTH-2:0], w_qbit};

  // Sign correction; a zero divisor leaves the dividend as remainder, so only LO needs forcing.
  assign w_prod     = r_acc[2*WIDTH-1:0];
  assign w_prod_fix = r_neg_q ? (-w_prod) : w_prod;
  assign w_quo_fix  = r_dz ? {WIDTH{1'b1}} :
                      (r_neg_q ? (-r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0]);
  assign w_rem_fix  = r_neg_r ? (-r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RUN;
      S_RUN:   if (r_cnt == CW'(WIDTH - 1)) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath, status flags and the architectural HI/LO registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      r_busy <= (w_next != S_IDLE);
      r_done <= (r_state == S_FIX);
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_cnt    <= '0;
            r_acc    <= {{(WIDTH+1){1'b0}}, w_mag_a};
            r_b      <= w_mag_b;
            r_is_div <= bus.op[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_dz     <= (bus.srcb == '0);
          end else begin
            if (bus.hiwrite) r_hi <= bus.srca;
            if (bus.lowrite) r_lo <= bus.srca;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + CW'(1);
          r_acc <= r_is_div ? w_div_next : w_mul_next;
        end
        S_FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
endmodule
